// File: rtl/mem_access_stage.sv
// M-stage pipeline register plus load/store unit for a req/ack memory.
// Ports: *_e E-stage inputs, mem_* memory bus, *_m registered/derived outputs.
module mem_access_stage #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int MAX_WAIT       = 15,
  localparam int LANE_BITS      = $clog2(DATA_WIDTH/8),
  localparam int BE_W           = DATA_WIDTH/8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      reg_write_e,
  input  logic                      mem_to_reg_e,
  input  logic                      mem_write_e,
  input  logic                      has_div_e,
  input  logic                      unsigned_e,
  input  logic [1:0]                size_e,
  input  logic [ADDR_WIDTH-1:0]     alu_out_e,
  input  logic [DATA_WIDTH-1:0]     write_data_e,
  input  logic [DATA_WIDTH-1:0]     div_hi_e,
  input  logic [DATA_WIDTH-1:0]     div_lo_e,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg_e,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [BE_W-1:0]           mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      reg_write_m,
  output logic                      mem_to_reg_m,
  output logic                      has_div_m,
  output logic [ADDR_WIDTH-1:0]     alu_out_m,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_m,
  output logic [DATA_WIDTH-1:0]     div_hi_m,
  output logic [DATA_WIDTH-1:0]     div_lo_m,
  output logic [DATA_WIDTH-1:0]     read_value_m,
  output logic                      stall_m,
  output logic                      misaligned_m,
  output logic                      bus_error_m
);

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_to_reg;
    logic                      mem_write;
    logic                      has_div;
    logic                      is_unsigned;
    logic [1:0]                size;
    logic [ADDR_WIDTH-1:0]     alu_out;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH-1:0]     div_hi;
    logic [DATA_WIDTH-1:0]     div_lo;
    logic [REG_ADDR_WIDTH-1:0] write_reg;
  } ex_mem_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  localparam logic [DATA_WIDTH-1:0] M8   = ONES >> (DATA_WIDTH-8);
  localparam logic [DATA_WIDTH-1:0] M16  = ONES >> (DATA_WIDTH-16);
  localparam logic [DATA_WIDTH-1:0] M32  = ONES >> (DATA_WIDTH-32);
  localparam logic [7:0]            MAXW = 8'(MAX_WAIT);

  ex_mem_t em_q, em_d;
  state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic                  access;
  logic                  misal;
  logic                  go;
  logic                  timeout;
  logic [LANE_BITS-1:0]  lane;
  logic [LANE_BITS+2:0]  bit_sh;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] mask;
  logic                  sign;

  always_comb begin
    em_d = em_q;
    if (!stall_m) begin
      em_d.reg_write   = reg_write_e;
      em_d.mem_to_reg  = mem_to_reg_e;
      em_d.mem_write   = mem_write_e;
      em_d.has_div     = has_div_e;
      em_d.is_unsigned = unsigned_e;
      em_d.size        = size_e;
      em_d.alu_out     = alu_out_e;
      em_d.write_data  = write_data_e;
      em_d.div_hi      = div_hi_e;
      em_d.div_lo      = div_lo_e;
      em_d.write_reg   = write_reg_e;
    end
  end

  always_comb begin
    access = em_q.mem_to_reg | em_q.mem_write;
    lane   = em_q.alu_out[LANE_BITS-1:0];
    bit_sh = {lane, 3'b000};
    misal  = 1'b0;
    mem_be = '1;
    mask   = ONES;
    unique case (em_q.size)
      2'b00: begin
        misal  = 1'b0;
        mem_be = BE_W'(1) << lane;
        mask   = M8;
      end
      2'b01: begin
        misal  = lane[0];
        mem_be = BE_W'(3) << lane;
        mask   = M16;
      end
      2'b10: begin
        misal  = |lane[1:0];
        mem_be = BE_W'(15) << lane;
        mask   = M32;
      end
      2'b11: begin
        misal  = (DATA_WIDTH == 32) || (|lane);
        mem_be = '1;
        mask   = ONES;
      end
    endcase
  end

  always_comb begin
    go      = access & ~misal;
    timeout = (state_q == S_WAIT) & ~mem_ack & (cnt_q == MAXW);
    mem_req = go;
    mem_we  = go & em_q.mem_write;
    stall_m = go & ~mem_ack & ~timeout;
    mem_addr = {em_q.alu_out[ADDR_WIDTH-1:LANE_BITS],
                LANE_BITS'(0)};
    mem_wdata = em_q.write_data << bit_sh;
  end

  // Sign bit sits at the top of the kept field; fill above it.
  always_comb begin
    rd_sh = mem_rdata >> bit_sh;
    unique case (em_q.size)
      2'b00:   sign = rd_sh[7];
      2'b01:   sign = rd_sh[15];
      2'b10:   sign = rd_sh[31];
      default: sign = rd_sh[DATA_WIDTH-1];
    endcase
    read_value_m = (rd_sh & mask)
                 | ((sign & ~em_q.is_unsigned) ? ~mask : '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!go) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!mem_ack) begin
            state_d = S_WAIT;
            cnt_d   = 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_ack || timeout) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      em_q    <= '0;
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      em_q    <= em_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign misaligned_m = access & misal;
  assign bus_error_m  = timeout;
  assign reg_write_m  = em_q.reg_write & ~misaligned_m & ~timeout;
  assign mem_to_reg_m = em_q.mem_to_reg;
  assign has_div_m    = em_q.has_div;
  assign alu_out_m    = em_q.alu_out;
  assign write_reg_m  = em_q.write_reg;
  assign div_hi_m     = em_q.div_hi;
  assign div_lo_m     = em_q.div_lo;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage (32-bit, MAX_WAIT=4)
// plus directed 64-bit dword and async-reset checks.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // 32-bit instance
  logic        rw_e = 0, m2r_e = 0, mw_e = 0, hd_e = 0, un_e = 0;
  logic [1:0]  sz_e = 0;
  logic [31:0] alu_e = 0, wd_e = 0;
  logic [4:0]  wr_e = 0;
  logic        req, we, ack = 0;
  logic [31:0] addr, wdata, rdata = 0;
  logic [3:0]  be;
  logic        rw_m, m2r_m, hd_m, stall, mis, berr;
  logic [31:0] alu_m, hi_m, lo_m, rv_m;
  logic [4:0]  wr_m;

  mem_access_stage #(.DATA_WIDTH(32), .MAX_WAIT(4)) u32 (
    .clock(clk), .reset_n(rst_n),
    .reg_write_e(rw_e), .mem_to_reg_e(m2r_e), .mem_write_e(mw_e),
    .has_div_e(hd_e), .unsigned_e(un_e), .size_e(sz_e),
    .alu_out_e(alu_e), .write_data_e(wd_e),
    .div_hi_e(32'h0), .div_lo_e(32'h0), .write_reg_e(wr_e),
    .mem_req(req), .mem_we(we), .mem_addr(addr), .mem_be(be),
    .mem_wdata(wdata), .mem_ack(ack), .mem_rdata(rdata),
    .reg_write_m(rw_m), .mem_to_reg_m(m2r_m), .has_div_m(hd_m),
    .alu_out_m(alu_m), .write_reg_m(wr_m),
    .div_hi_m(hi_m), .div_lo_m(lo_m), .read_value_m(rv_m),
    .stall_m(stall), .misaligned_m(mis), .bus_error_m(berr)
  );

  // 64-bit instance
  logic        rw6 = 0, m2r6 = 0;
  logic [1:0]  sz6 = 0;
  logic [31:0] alu6 = 0;
  logic [4:0]  wr6 = 0;
  logic        req6, we6, ack6 = 0;
  logic [31:0] addr6;
  logic [63:0] wdata6, rdata6 = 0;
  logic [7:0]  be6;
  logic        rw_m6, m2r_m6, hd_m6, stall6, mis6, berr6;
  logic [31:0] alu_m6;
  logic [63:0] hi_m6, lo_m6, rv_m6;
  logic [4:0]  wr_m6;

  mem_access_stage #(.DATA_WIDTH(64)) u64 (
    .clock(clk), .reset_n(rst_n),
    .reg_write_e(rw6), .mem_to_reg_e(m2r6), .mem_write_e(1'b0),
    .has_div_e(1'b0), .unsigned_e(1'b0), .size_e(sz6),
    .alu_out_e(alu6), .write_data_e(64'h0),
    .div_hi_e(64'h0), .div_lo_e(64'h0), .write_reg_e(wr6),
    .mem_req(req6), .mem_we(we6), .mem_addr(addr6), .mem_be(be6),
    .mem_wdata(wdata6), .mem_ack(ack6), .mem_rdata(rdata6),
    .reg_write_m(rw_m6), .mem_to_reg_m(m2r_m6), .has_div_m(hd_m6),
    .alu_out_m(alu_m6), .write_reg_m(wr_m6),
    .div_hi_m(hi_m6), .div_lo_m(lo_m6), .read_value_m(rv_m6),
    .stall_m(stall6), .misaligned_m(mis6), .bus_error_m(berr6)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  tag;
    int          stalls;
    logic        req, rw, mis, berr;
    logic        chk_be, chk_rv, chk_wd;
    logic [3:0]  be;
    logic [31:0] rv, wd;
  } exp_t;

  exp_t q[$];

  // Memory model: ack after cur_d wait cycles of the op in M.
  int          nxt_d = 0, cur_d = 0, wc = 0;
  logic [31:0] nxt_r = 0, cur_r = 0;

  always @(posedge clk) begin
    if (!stall) begin
      wc = 0;
      cur_d = nxt_d;
      cur_r = nxt_r;
    end else begin
      wc++;
    end
    #1;
    ack = req && (wc == cur_d);
    rdata = cur_r;
  end

  // Monitor: one scoreboard entry per completed tagged op.
  int          scnt = 0;
  logic        unstable = 0;
  logic [31:0] a0, w0;
  logic [3:0]  b0;
  logic        r0, we0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall) begin
        if (scnt == 0) begin
          a0 = addr; w0 = wdata; b0 = be; r0 = req; we0 = we;
        end else if (addr !== a0 || wdata !== w0 || be !== b0 ||
                     req !== r0 || we !== we0) begin
          unstable = 1;
        end
        scnt++;
      end else if (wr_m != 0) begin
        if (scnt > 0 && (addr !== a0 || wdata !== w0 ||
                         be !== b0 || req !== r0 || we !== we0))
          unstable = 1;
        if (q.size() == 0) begin
          chk("unexpected_op", 64'(wr_m), 64'h0);
        end else begin
          exp_t e;
          logic [31:0] bm;
          e = q.pop_front();
          chk($sformatf("op%0d_tag", e.tag), 64'(wr_m), 64'(e.tag));
          chk($sformatf("op%0d_stalls", e.tag), 64'(scnt),
              64'(e.stalls));
          chk($sformatf("op%0d_stable", e.tag), 64'(unstable), 64'h0);
          chk($sformatf("op%0d_req", e.tag), 64'(req), 64'(e.req));
          chk($sformatf("op%0d_regwr", e.tag), 64'(rw_m), 64'(e.rw));
          chk($sformatf("op%0d_mis", e.tag), 64'(mis), 64'(e.mis));
          chk($sformatf("op%0d_berr", e.tag), 64'(berr), 64'(e.berr));
          if (e.chk_be)
            chk($sformatf("op%0d_be", e.tag), 64'(be), 64'(e.be));
          if (e.chk_rv)
            chk($sformatf("op%0d_rv", e.tag), 64'(rv_m), 64'(e.rv));
          if (e.chk_wd) begin
            bm = {{8{e.be[3]}}, {8{e.be[2]}},
                  {8{e.be[1]}}, {8{e.be[0]}}};
            chk($sformatf("op%0d_wdata", e.tag), 64'(wdata & bm),
                64'(e.wd));
            chk($sformatf("op%0d_we", e.tag), 64'(we), 64'h1);
          end
        end
        scnt = 0;
        unstable = 0;
      end
    end
  end

  task automatic issue(input logic rw, m2r, mw, un,
                       input logic [1:0] sz,
                       input logic [31:0] a, wd,
                       input logic [4:0] tag,
                       input int dly, input logic [31:0] rd,
                       input exp_t e);
    int n = 0;
    while (stall && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("issue_timeout", 64'(stall), 64'h0);
    rw_e = rw; m2r_e = m2r; mw_e = mw; un_e = un; sz_e = sz;
    alu_e = a; wd_e = wd; wr_e = tag;
    nxt_d = dly; nxt_r = rd;
    if (tag != 0) q.push_back(e);
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [4:0] tag, input int st,
                              input logic rq, rw, ms, be_r,
                              input logic cb, cr, cw,
                              input logic [3:0] b,
                              input logic [31:0] rv, wd);
    exp_t e;
    e.tag = tag; e.stalls = st; e.req = rq; e.rw = rw; e.mis = ms;
    e.berr = be_r; e.chk_be = cb; e.chk_rv = cr; e.chk_wd = cw;
    e.be = b; e.rv = rv; e.wd = wd;
    return e;
  endfunction

  initial begin
    exp_t nop;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    #12;
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_req", 64'(req), 64'h0);
    chk("rst_regwr", 64'(rw_m), 64'h0);
    chk("rst_alu", 64'(alu_m), 64'h0);
    chk("rst_stall64", 64'(stall6), 64'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // word load, zero wait
    issue(1, 1, 0, 0, 2'b10, 32'h100, 0, 1, 0, 32'hDEADBEEF,
          mk(1, 0, 1, 1, 0, 0, 1, 1, 0, 4'hF, 32'hDEADBEEF, 0));
    // signed / unsigned byte at 0x103
    issue(1, 1, 0, 0, 2'b00, 32'h103, 0, 2, 0, 32'h80112233,
          mk(2, 0, 1, 1, 0, 0, 1, 1, 0, 4'h8, 32'hFFFFFF80, 0));
    issue(1, 1, 0, 1, 2'b00, 32'h103, 0, 3, 0, 32'h80112233,
          mk(3, 0, 1, 1, 0, 0, 1, 1, 0, 4'h8, 32'h00000080, 0));
    // half store at 0x202, ack after 3 wait cycles
    issue(0, 0, 1, 0, 2'b01, 32'h202, 32'h1234ABCD, 4, 3, 0,
          mk(4, 3, 1, 0, 0, 0, 1, 0, 1, 4'hC, 0, 32'hABCD0000));
    // timeout: never acked
    issue(1, 1, 0, 0, 2'b10, 32'h300, 0, 5, 99, 0,
          mk(5, 4, 1, 0, 0, 1, 1, 0, 0, 4'hF, 0, 0));
    // misaligned word load
    issue(1, 1, 0, 0, 2'b10, 32'h106, 0, 6, 0, 0,
          mk(6, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0, 0));
    // plain ALU op
    issue(1, 0, 0, 0, 2'b10, 32'h55, 0, 7, 0, 0,
          mk(7, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0));
    // half loads at lane 2, one wait cycle then zero wait
    issue(1, 1, 0, 0, 2'b01, 32'h2, 0, 8, 1, 32'h80010000,
          mk(8, 1, 1, 1, 0, 0, 1, 1, 0, 4'hC, 32'hFFFF8001, 0));
    issue(1, 1, 0, 1, 2'b01, 32'h2, 0, 9, 0, 32'h80010000,
          mk(9, 0, 1, 1, 0, 0, 1, 1, 0, 4'hC, 32'h00008001, 0));
    issue(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, nop);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'h0);

    // 64-bit dword load, zero wait
    rw6 = 1; m2r6 = 1; sz6 = 2'b11; alu6 = 32'h08; wr6 = 1;
    ack6 = 1; rdata6 = 64'h0123456789ABCDEF;
    @(negedge clk);
    chk("d64_rv", rv_m6, 64'h0123456789ABCDEF);
    chk("d64_be", 64'(be6), 64'hFF);
    chk("d64_stall", 64'(stall6), 64'h0);
    chk("d64_addr", 64'(addr6), 64'h8);
    alu6 = 32'h10; wr6 = 2;
    @(posedge clk);
    #1 ack6 = 0;
    @(negedge clk);
    chk("d64_wait1_stall", 64'(stall6), 64'h1);
    chk("d64_wait1_req", 64'(req6), 64'h1);
    @(negedge clk);
    chk("d64_wait2_stall", 64'(stall6), 64'h1);
    #2 rst_n = 0;
    #1;
    chk("arst_req", 64'(req6), 64'h0);
    chk("arst_stall", 64'(stall6), 64'h0);
    chk("arst_regwr", 64'(rw_m6), 64'h0);
    chk("arst_alu", 64'(alu_m6), 64'h0);
    chk("arst_wreg", 64'(wr_m6), 64'h0);
    chk("arst_m2r", 64'(m2r_m6), 64'h0);
    rw6 = 1; m2r6 = 0; alu6 = 32'h18; wr6 = 3;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_alu", 64'(alu_m6), 64'h18);
    chk("post_rst_wreg", 64'(wr_m6), 64'h3);
    chk("post_rst_stall", 64'(stall6), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
